tdc_array: RTL and testbench

TDC_ARRAY -- requirements
Module: tdc_array

---
 rtl/tdc_array.sv | 206 ++++++++++++++++++++
 tb/tb_tdc_array.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_array.sv
// tdc_array: multi-channel time-to-digital converter.
// Each channel runs an IDLE/RUN/DONE FSM that counts prescaled clock edges
// between a start edge and a stop edge. Finished channels are drained one per
// cycle through a round-robin arbiter into a single valid/ready result register.
// Optional build macro: TDC_SATURATE_EN (saturate the count at all-ones and
// finish the measurement instead of wrapping).
module tdc_array #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NCH-1:0]                       start,
    input  logic [NCH-1:0]                       stop,
    output logic [NCH-1:0]                       ro_en,
    output logic [NCH-1:0]                       busy,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic [CNT_W-1:0]                     result_data,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] result_ch,
    output logic                                 result_ovf,
    output logic                                 result_drop
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q [NCH];
    state_t                state_d [NCH];
    logic [PRESCALE_W-1:0] pre_q   [NCH];
    logic [PRESCALE_W-1:0] pre_d   [NCH];
    logic [CNT_W-1:0]      cnt_q   [NCH];
    logic [CNT_W-1:0]      cnt_d   [NCH];
    logic [NCH-1:0]        ovf_q, ovf_d;
    logic [NCH-1:0]        drop_q, drop_d;

    logic [NCH-1:0]        start_q, stop_q;
    logic [NCH-1:0]        start_edge, stop_edge;
    logic                  prime_q;

    logic [CH_W-1:0]       last_q;
    logic [CH_W-1:0]       grant_ch;
    logic [CH_W-1:0]       cand;
    logic                  found;
    logic                  take;
    logic                  grant_vld;

    logic                  rv_q;
    logic [CNT_W-1:0]      rdata_q;
    logic [CH_W-1:0]       rch_q;
    logic                  rovf_q;
    logic                  rdrop_q;

    // prime_q masks the first cycle after reset so inputs already high at release are not edges
    assign start_edge = start & ~start_q & {NCH{prime_q}};
    assign stop_edge  = stop  & ~stop_q  & {NCH{prime_q}};

    // Input history registers for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            stop_q  <= '0;
            prime_q <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            prime_q <= 1'b1;
        end
    end

    // Round-robin pick of a DONE channel, searching from the one after the last grant
    always_comb begin
        found    = 1'b0;
        grant_ch = '0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CH_W'((int'(last_q) + k) % NCH);
            if (!found && state_q[cand] == S_DONE) begin
                found    = 1'b1;
                grant_ch = cand;
            end
        end
        take      = !rv_q || result_ready;
        grant_vld = found && take;
    end

    // Per-channel next-state, prescaler/count and sticky flag logic
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            pre_d[i]   = pre_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (start_edge[i]) begin
                        state_d[i] = S_RUN;
                        pre_d[i]   = '0;
                        cnt_d[i]   = '0;
                        ovf_d[i]   = 1'b0;
                    end
                end
                S_RUN: begin
                    if (start_edge[i]) begin
                        drop_d[i] = 1'b1;
                    end
                    pre_d[i] = pre_q[i] + 1'b1;
                    if (stop_edge[i]) begin
                        state_d[i] = S_DONE;
                    end
                    if (pre_q[i] == '1) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
`ifdef TDC_SATURATE_EN
                        if (cnt_q[i] == CNT_MAX - CNT_W'(1)) begin
                            ovf_d[i]   = 1'b1;
                            state_d[i] = S_DONE;
                        end
`else
                        if (cnt_q[i] == CNT_MAX) begin
                            ovf_d[i] = 1'b1;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (start_edge[i]) begin
                        drop_d[i] = 1'b1;
                    end
                    if (grant_vld && grant_ch == CH_W'(i)) begin
                        state_d[i] = S_IDLE;
                        ovf_d[i]   = 1'b0;
                        drop_d[i]  = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase
        end
    end

    // Per-channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                pre_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            ovf_q  <= '0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                pre_q[i]   <= pre_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Result register: load on grant, otherwise drain when the consumer accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q    <= 1'b0;
            rdata_q <= '0;
            rch_q   <= '0;
            rovf_q  <= 1'b0;
            rdrop_q <= 1'b0;
            last_q  <= CH_W'(NCH - 1);
        end else if (grant_vld) begin
            rv_q    <= 1'b1;
            rdata_q <= cnt_q[grant_ch];
            rch_q   <= grant_ch;
            rovf_q  <= ovf_q[grant_ch];
            rdrop_q <= drop_q[grant_ch];
            last_q  <= grant_ch;
        end else if (result_ready) begin
            rv_q    <= 1'b0;
        end
    end

    // Status outputs decoded straight from the state registers
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ro_en[i] = (state_q[i] == S_RUN);
            busy[i]  = (state_q[i] != S_IDLE);
        end
    end

    assign result_valid = rv_q;
    assign result_data  = rdata_q;
    assign result_ch    = rch_q;
    assign result_ovf   = rovf_q;
    assign result_drop  = rdrop_q;

endmodule

// File: tb/tb_tdc_array.sv
// tb_tdc_array: directed, table-driven bench for tdc_array (NCH=4, CNT_W=8, P=4).
module tb_tdc_array;

    localparam int NCH        = 4;
    localparam int CNT_W      = 8;
    localparam int PRESCALE_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NCH-1:0]   start = '0;
    logic [NCH-1:0]   stop = '0;
    logic [NCH-1:0]   ro_en;
    logic [NCH-1:0]   busy;
    logic             result_valid;
    logic             result_ready = 1'b1;
    logic [CNT_W-1:0] result_data;
    logic [1:0]       result_ch;
    logic             result_ovf;
    logic             result_drop;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ch;
        int n;
        int data;
        int ovf;
        int lat;
    } vec_t;

    vec_t vt [7];

    tdc_array #(
        .NCH(NCH),
        .CNT_W(CNT_W),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .ro_en(ro_en),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data(result_data),
        .result_ch(result_ch),
        .result_ovf(result_ovf),
        .result_drop(result_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One measurement on one channel: start edge, stop edge n edges later.
    task automatic measure(input int ch, input int n,
                           output logic [7:0] d, output logic [1:0] c,
                           output logic o, output logic dr,
                           output int lat, output logic ro_mid);
        bit seen;
        seen = 1'b0;
        lat = -1; d = '0; c = '0; o = 1'b0; dr = 1'b0; ro_mid = 1'b0;
        start[ch] = 1'b1;
        step();
        start[ch] = 1'b0;
        for (int k = 1; k <= n + 5; k++) begin
            if (k == n) stop[ch] = 1'b1;
            step();
            if (k == n) stop[ch] = 1'b0;
            if (k == 1) ro_mid = ro_en[ch];
            if (!seen && result_valid) begin
                seen = 1'b1;
                d = result_data; c = result_ch; o = result_ovf; dr = result_drop;
                lat = k;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ro_en"}, ro_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_data"}, result_data, 0);
        chk({tag, "_ch"}, result_ch, 0);
        chk({tag, "_ovf"}, result_ovf, 0);
        chk({tag, "_drop"}, result_drop, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] c;
        logic       o, dr, rm;
        int         lat;

        vt[0] = '{ch: 0, n: 41,   data: 10,  ovf: 0, lat: 42};
        vt[1] = '{ch: 1, n: 3,    data: 0,   ovf: 0, lat: 4};
        vt[2] = '{ch: 2, n: 4,    data: 1,   ovf: 0, lat: 5};
        vt[3] = '{ch: 3, n: 7,    data: 1,   ovf: 0, lat: 8};
`ifdef TDC_SATURATE_EN
        vt[4] = '{ch: 0, n: 1030, data: 255, ovf: 1, lat: 1021};
        vt[5] = '{ch: 1, n: 1024, data: 255, ovf: 1, lat: 1021};
        vt[6] = '{ch: 2, n: 1023, data: 255, ovf: 1, lat: 1021};
`else
        vt[4] = '{ch: 0, n: 1030, data: 1,   ovf: 1, lat: 1031};
        vt[5] = '{ch: 1, n: 1024, data: 0,   ovf: 1, lat: 1025};
        vt[6] = '{ch: 2, n: 1023, data: 255, ovf: 0, lat: 1024};
`endif

        // Reset state
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_async");
        repeat (3) step();
        chk_all_zero("rst_hold");
        rst = 1'b0;
        repeat (2) step();
        chk_all_zero("post_rst");

        // Table-driven single-channel measurements
        for (int v = 0; v < 7; v++) begin
            measure(vt[v].ch, vt[v].n, d, c, o, dr, lat, rm);
            chk($sformatf("vec%0d_data", v), d, vt[v].data);
            chk($sformatf("vec%0d_ch", v), c, vt[v].ch);
            chk($sformatf("vec%0d_ovf", v), o, vt[v].ovf);
            chk($sformatf("vec%0d_drop", v), dr, 0);
            chk($sformatf("vec%0d_lat", v), lat, vt[v].lat);
            chk($sformatf("vec%0d_ro_en", v), rm, 1);
        end

        // Set arbiter pointer to ch0, then batch on ch1..3
        measure(0, 5, d, c, o, dr, lat, rm);
        chk("pre_batch_data", d, 1);
        start = 4'b1110;
        step();
        start = '0;
        repeat (7) step();
        stop = 4'b1110;
        step();
        stop = '0;
        chk("batch1_busy", busy, 4'b1110);
        chk("batch1_ro_en", ro_en, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("batch1_valid%0d", j), result_valid, 1);
            chk($sformatf("batch1_ch%0d", j), result_ch, j + 1);
            chk($sformatf("batch1_data%0d", j), result_data, 2);
        end
        step();
        chk("batch1_end_valid", result_valid, 0);

        // Second batch on all channels: search resumes after ch3
        start = 4'b1111;
        step();
        start = '0;
        repeat (11) step();
        stop = 4'b1111;
        step();
        stop = '0;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("batch2_valid%0d", j), result_valid, 1);
            chk($sformatf("batch2_ch%0d", j), result_ch, j);
            chk($sformatf("batch2_data%0d", j), result_data, 3);
        end
        step();
        chk("batch2_end_valid", result_valid, 0);

        // Back-pressure: held result stays put while ch2 waits in DONE
        result_ready = 1'b0;
        start = 4'b0101;
        step();
        start = '0;
        repeat (7) step();
        stop = 4'b0001;
        step();
        stop = '0;
        step();
        chk("hold_first_valid", result_valid, 1);
        chk("hold_first_ch", result_ch, 0);
        chk("hold_first_data", result_data, 2);
        repeat (2) step();
        stop = 4'b0100;
        step();
        stop = '0;
        chk("hold_ch2_busy", busy[2], 1);
        chk("hold_ch2_ro_en", ro_en[2], 0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("hold_valid%0d", j), result_valid, 1);
            chk($sformatf("hold_ch%0d", j), result_ch, 0);
            chk($sformatf("hold_data%0d", j), result_data, 2);
            chk($sformatf("hold_busy%0d", j), busy[2], 1);
        end
        result_ready = 1'b1;
        step();
        chk("hold_release_valid", result_valid, 1);
        chk("hold_release_ch", result_ch, 2);
        chk("hold_release_data", result_data, 3);
        step();
        chk("hold_after_valid", result_valid, 0);
        chk("hold_after_busy", busy, 0);

        // Dropped start on ch0, then reset while ch1 is running
        start = 4'b0011;
        step();
        start = '0;
        step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (5) step();
        stop = 4'b0001;
        step();
        stop = '0;
        step();
        chk("drop_valid", result_valid, 1);
        chk("drop_flag", result_drop, 1);
        chk("drop_data", result_data, 2);
        chk("drop_ch", result_ch, 0);
        step();
        chk("drop_ch1_running", ro_en[1], 1);
        start[1] = 1'b1;
        rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        repeat (2) step();
        rst = 1'b0;
        begin
            bit any_valid;
            bit any_busy;
            any_valid = 1'b0;
            any_busy  = 1'b0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (result_valid) any_valid = 1'b1;
                if (busy != 0 || ro_en != 0) any_busy = 1'b1;
            end
            chk("after_rst_no_result", any_valid, 0);
            chk("after_rst_no_edge", any_busy, 0);
        end
        start[1] = 1'b0;
        step();

        // Flags cleared by reset: next ch0 result is clean
        measure(0, 5, d, c, o, dr, lat, rm);
        chk("post_rst_data", d, 1);
        chk("post_rst_drop", dr, 0);
        chk("post_rst_ovf", o, 0);
        chk("post_rst_lat", lat, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
